adc_frame_packetizer: RTL and testbench

Captures a fixed-length burst of ADC samples from the LTC2312 sample stream into an internal buffer. It then emits the burst as a framed byte stream on an AXI-Stream-style byte interface that feeds axis_uart_tx_wrapper. The frame carries sync, sequence number, length, payload and an optional checksum, so the host can resynchronise and detect loss. It replaces the bare FIFO-dump path between the ADC core and the UART transmitter.

---
 rtl/adc_frame_packetizer.sv | 259 +++++++++++++++++++++++++
 tb/tb_adc_frame_packetizer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packetizer.sv
// adc_frame_packetizer: captures FRAME_LEN ADC samples into a local RAM,
// then streams them as a framed byte stream toward the UART transmitter.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              one-cycle request to capture and send a frame
//   i_tdata, i_tvalid  ADC sample stream (no backpressure)
//   enable             run enable to the ADC core (high while capturing)
//   o_tdata, o_tvalid  registered frame byte and its valid
//   o_tready           byte accepted when high with o_tvalid
//   busy               high whenever the packetizer is not idle
//
// Frame: A5 5A seq LEN_HI LEN_LO {MSB LSB} x FRAME_LEN [checksum]
// Define ADC_FRAME_CHECKSUM_EN to append the checksum trailer byte
// (sum mod 256 of every byte after the sync pair).

module adc_frame_packetizer #(
   parameter int WIDTH     = 14,
   parameter int FRAME_LEN = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tvalid,
   output logic             enable,
   output logic [7:0]       o_tdata,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic             busy
);

   localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int BW = AW + 2;

   localparam logic [AW-1:0] WR_LAST  = AW'(FRAME_LEN - 1);
   localparam logic [BW-1:0] PAY_DONE = BW'(2 * FRAME_LEN);
   localparam logic [15:0]   LEN16    = 16'(FRAME_LEN);
`ifdef ADC_FRAME_CHECKSUM_EN
   localparam logic [BW-1:0] PAY_LAST = BW'(2 * FRAME_LEN - 1);
`endif

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CAPTURE = 3'd1;
   localparam logic [2:0] S_HEADER  = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
`ifdef ADC_FRAME_CHECKSUM_EN
   localparam logic [2:0] S_TRAILER = 3'd4;
`endif

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [7:0]    lsb_q, lsb_d;
   logic [7:0]    seq_q, seq_d;
   logic [7:0]    o_tdata_q, o_tdata_d;
   logic          o_tvalid_q, o_tvalid_d;
   logic          enable_q, enable_d;
   logic          busy_q, busy_d;
`ifdef ADC_FRAME_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   logic [15:0]   sample_ext;
   logic [15:0]   rdata_q;
   logic [15:0]   mem [FRAME_LEN];
   logic          ram_we;
   logic [AW-1:0] ram_addr;

   logic [7:0]    nxt_byte;
   logic          have_byte;
   logic          can_load;
   logic          accept;
   logic          load;

   assign sample_ext = 16'(i_tdata);

   // Single-port RAM; the read port follows rd_addr_q outside CAPTURE,
   // so rdata_q always holds the sample the next MSB byte will need.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= sample_ext;
      end
      rdata_q <= mem[ram_addr];
   end

   always_comb begin
      have_byte = 1'b0;
      nxt_byte  = 8'h00;
      unique case (state_q)
         S_HEADER: begin
            have_byte = 1'b1;
            case (bcnt_q[2:0])
               3'd0:    nxt_byte = 8'hA5;
               3'd1:    nxt_byte = 8'h5A;
               3'd2:    nxt_byte = seq_q;
               3'd3:    nxt_byte = LEN16[15:8];
               default: nxt_byte = LEN16[7:0];
            endcase
         end
         S_PAYLOAD: begin
            have_byte = (bcnt_q != PAY_DONE);
            nxt_byte  = bcnt_q[0] ? lsb_q : rdata_q[15:8];
         end
`ifdef ADC_FRAME_CHECKSUM_EN
         S_TRAILER: begin
            have_byte = (bcnt_q == '0);
            nxt_byte  = sum_q;
         end
`endif
         default: begin
            have_byte = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      rd_addr_d  = rd_addr_q;
      bcnt_d     = bcnt_q;
      lsb_d      = lsb_q;
      seq_d      = seq_q;
`ifdef ADC_FRAME_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      ram_we     = 1'b0;
      ram_addr   = rd_addr_q;
      can_load   = !o_tvalid_q || o_tready;
      accept     = o_tvalid_q && o_tready;
      load       = have_byte && can_load;
      o_tvalid_d = o_tvalid_q && !o_tready;
      o_tdata_d  = o_tdata_q;

      if (load) begin
         o_tdata_d  = nxt_byte;
         o_tvalid_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_CAPTURE;
               wr_cnt_d = '0;
            end
         end
         S_CAPTURE: begin
            ram_addr = wr_cnt_q;
            if (i_tvalid) begin
               ram_we   = 1'b1;
               wr_cnt_d = wr_cnt_q + AW'(1);
               if (wr_cnt_q == WR_LAST) begin
                  state_d   = S_HEADER;
                  bcnt_d    = '0;
                  rd_addr_d = '0;
`ifdef ADC_FRAME_CHECKSUM_EN
                  sum_d     = 8'h00;
`endif
               end
            end
         end
         S_HEADER: begin
            if (load) begin
               bcnt_d = bcnt_q + BW'(1);
`ifdef ADC_FRAME_CHECKSUM_EN
               if (bcnt_q >= BW'(2)) begin
                  sum_d = sum_q + nxt_byte;
               end
`endif
               if (bcnt_q[2:0] == 3'd4) begin
                  state_d = S_PAYLOAD;
                  bcnt_d  = '0;
               end
            end
         end
         S_PAYLOAD: begin
            if (load) begin
               bcnt_d = bcnt_q + BW'(1);
`ifdef ADC_FRAME_CHECKSUM_EN
               sum_d  = sum_q + nxt_byte;
`endif
               // MSB going out: park the LSB and prefetch the next sample.
               if (!bcnt_q[0]) begin
                  lsb_d     = rdata_q[7:0];
                  rd_addr_d = rd_addr_q + AW'(1);
               end
`ifdef ADC_FRAME_CHECKSUM_EN
               if (bcnt_q == PAY_LAST) begin
                  state_d = S_TRAILER;
                  bcnt_d  = '0;
               end
`endif
            end
`ifndef ADC_FRAME_CHECKSUM_EN
            if (!have_byte && accept) begin
               state_d = S_IDLE;
               seq_d   = seq_q + 8'd1;
            end
`endif
         end
`ifdef ADC_FRAME_CHECKSUM_EN
         S_TRAILER: begin
            if (load) begin
               bcnt_d = BW'(1);
            end
            if (!have_byte && accept) begin
               state_d = S_IDLE;
               seq_d   = seq_q + 8'd1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      enable_d = (state_d == S_CAPTURE);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wr_cnt_q   <= '0;
         rd_addr_q  <= '0;
         bcnt_q     <= '0;
         lsb_q      <= 8'h00;
         seq_q      <= 8'h00;
         o_tdata_q  <= 8'h00;
         o_tvalid_q <= 1'b0;
         enable_q   <= 1'b0;
         busy_q     <= 1'b0;
`ifdef ADC_FRAME_CHECKSUM_EN
         sum_q      <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_addr_q  <= rd_addr_d;
         bcnt_q     <= bcnt_d;
         lsb_q      <= lsb_d;
         seq_q      <= seq_d;
         o_tdata_q  <= o_tdata_d;
         o_tvalid_q <= o_tvalid_d;
         enable_q   <= enable_d;
         busy_q     <= busy_d;
`ifdef ADC_FRAME_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   assign enable   = enable_q;
   assign o_tdata  = o_tdata_q;
   assign o_tvalid = o_tvalid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_adc_frame_packetizer.sv
// tb_adc_frame_packetizer: directed frame vectors for adc_frame_packetizer
// (FRAME_LEN=4, WIDTH=14); follows ADC_FRAME_CHECKSUM_EN when defined.

module tb_adc_frame_packetizer;

   localparam int WIDTH = 14;
   localparam int FLEN  = 4;
`ifdef ADC_FRAME_CHECKSUM_EN
   localparam int NB = 6 + 2 * FLEN;
`else
   localparam int NB = 5 + 2 * FLEN;
`endif
   localparam bit [3:0] RDY_PAT = 4'b1001;

   typedef struct {
      logic [3:0][15:0] smp;
      bit               stall;
      logic [7:0]       seq;
      logic [7:0]       ck;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] i_tdata;
   logic             i_tvalid;
   logic             enable;
   logic [7:0]       o_tdata;
   logic             o_tvalid;
   logic             o_tready;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   logic [7:0] bq[$];
   int         cq[$];
   bit         hold_v = 1'b0;
   logic [7:0] hold_d = 8'h00;
   int         stall_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   adc_frame_packetizer #(
      .WIDTH     (WIDTH),
      .FRAME_LEN (FLEN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .i_tdata  (i_tdata),
      .i_tvalid (i_tvalid),
      .enable   (enable),
      .o_tdata  (o_tdata),
      .o_tvalid (o_tvalid),
      .o_tready (o_tready),
      .busy     (busy)
   );

   always @(negedge clk) begin
      if (hold_v && !(o_tvalid === 1'b1 && o_tdata === hold_d)) begin
         stall_err++;
      end
      hold_v = (o_tvalid === 1'b1) && (o_tready === 1'b0);
      hold_d = o_tdata;
      if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
         bq.push_back(o_tdata);
         cq.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d,
                               input bit st, input logic [7:0] sq,
                               input logic [7:0] ck);
      vec_t v;
      v.smp[0] = a;
      v.smp[1] = b;
      v.smp[2] = c;
      v.smp[3] = d;
      v.stall  = st;
      v.seq    = sq;
      v.ck     = ck;
      return v;
   endfunction

   function automatic logic [7:0] exp_byte(input vec_t v, input int k);
      logic [15:0] len16;
      logic [15:0] w;
      len16 = 16'(FLEN);
      if (k == 0) return 8'hA5;
      if (k == 1) return 8'h5A;
      if (k == 2) return v.seq;
      if (k == 3) return len16[15:8];
      if (k == 4) return len16[7:0];
      if (k < 5 + 2 * FLEN) begin
         w = v.smp[(k - 5) / 2];
         return ((k - 5) % 2 == 0) ? w[15:8] : w[7:0];
      end
      return v.ck;
   endfunction

   task automatic do_vec(input vec_t v, input bit noise, input bit full);
      int last;
      bq.delete();
      cq.delete();
      if (noise) begin
         i_tdata  = 14'h3ABC;
         i_tvalid = 1'b1;
         tick();
         tick();
      end
      start = 1'b1;
      tick();
      start    = 1'b0;
      i_tvalid = 1'b0;
      chk("busy_rise", busy, 1);
      chk("enable_rise", enable, 1);
      for (int i = 0; i < FLEN; i++) begin
         if (noise) begin
            i_tvalid = 1'b0;
            tick();
         end
         i_tdata  = v.smp[i][WIDTH-1:0];
         i_tvalid = 1'b1;
         tick();
      end
      i_tvalid = 1'b0;
      chk("enable_fall", enable, 0);
      chk("tvalid_pre_hdr", o_tvalid, 0);
      if (noise) begin
         i_tdata  = 14'h3333;
         i_tvalid = 1'b1;
         start    = 1'b1;
      end
      tick();
      chk("sync0_valid", o_tvalid, 1);
      chk("sync0_data", o_tdata, 8'hA5);
      for (int c = 0; c < 200 && busy; c++) begin
         o_tready = v.stall ? RDY_PAT[c % 4] : 1'b1;
         tick();
      end
      start    = 1'b0;
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      chk("frame_done", busy, 0);
      chk("tvalid_idle", o_tvalid, 0);
      chk("byte_count", bq.size(), NB);
      if (bq.size() > 2) begin
         chk("seq_field", bq[2], v.seq);
      end
      if (full) begin
         for (int k = 0; k < NB && k < bq.size(); k++) begin
            chk($sformatf("byte%0d", k), bq[k], exp_byte(v, k));
         end
         if (bq.size() > 0) begin
            last = cq[bq.size() - 1];
            chk("busy_drop_cycle", cyc - last, 1);
            if (!v.stall) begin
               chk("consecutive", last - cq[0], bq.size() - 1);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl [5];
      tbl[0] = mk(16'h0001, 16'h1FFF, 16'h2000, 16'h3FFF, 1'b0, 8'h00, 8'h81);
      tbl[1] = mk(16'h0001, 16'h1FFF, 16'h2000, 16'h3FFF, 1'b1, 8'h01, 8'h82);
      tbl[2] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'h02, 8'h06);
      tbl[3] = mk(16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF, 1'b1, 8'h03, 8'hFF);
      tbl[4] = mk(16'h1234, 16'h0ABC, 16'h2FED, 16'h0101, 1'b0, 8'h04, 8'h32);

      rst_n    = 1'b0;
      start    = 1'b0;
      i_tdata  = '0;
      i_tvalid = 1'b0;
      o_tready = 1'b0;
      tick();
      tick();
      chk("rst_enable", enable, 0);
      chk("rst_tvalid", o_tvalid, 0);
      chk("rst_tdata", o_tdata, 8'h00);
      chk("rst_busy", busy, 0);

      rst_n    = 1'b1;
      o_tready = 1'b1;
      repeat (3) tick();
      chk("idle_tready_tvalid", o_tvalid, 0);
      chk("idle_busy", busy, 0);

      for (int t = 0; t < 5; t++) begin
         do_vec(tbl[t], 1'b0, 1'b1);
      end

      do_vec(mk(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1, 8'h05, 8'hB3),
             1'b1, 1'b1);
      repeat (3) tick();
      chk("no_extra_frame", busy, 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < FLEN; i++) begin
         i_tdata  = 14'(16'h0100 + i);
         i_tvalid = 1'b1;
         tick();
      end
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      repeat (8) tick();
      chk("mid_payload_valid", o_tvalid, 1);
      rst_n = 1'b0;
      tick();
      chk("abort_tvalid", o_tvalid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_enable", enable, 0);
      rst_n = 1'b1;
      tick();
      do_vec(tbl[0], 1'b0, 1'b1);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int f = 0; f < 257; f++) begin
         do_vec(mk(16'(f), 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'(f), 8'h00),
                1'b0, 1'b0);
      end

      chk("stall_hold", stall_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
